wts_adsr_envelope_generator_nch: RTL



---
 rtl/wts_adsr_envelope_generator_nch.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wts_adsr_envelope_generator_nch.sv
// N-channel time-multiplexed ADSR envelope generator: one shared datapath serves the `active` channel each clock.
// Optional WTS_ADSR_LEGATO_EN: key_on during ATTACK/DECAY/SUSTAIN re-attacks from the current level.
module wts_adsr_envelope_generator_nch #(
  parameter int CH_NUM       = 5,
  parameter int CH_BITS      = 3,
  parameter int LEVEL_BITS   = 7,
  parameter int COUNTER_BITS = 20
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic [CH_BITS-1:0]      active,
  input  logic [CH_BITS-1:0]      key_ch,
  input  logic                    key_on,
  input  logic                    key_release,
  input  logic                    key_off,
  input  logic [CH_NUM-1:0]       adsr_en,
  input  logic [7:0]              reg_ar,
  input  logic [7:0]              reg_dr,
  input  logic [7:0]              reg_sr,
  input  logic [7:0]              reg_rr,
  input  logic [LEVEL_BITS-2:0]   reg_sl,
  output logic [LEVEL_BITS-1:0]   envelope,
  output logic [CH_NUM-1:0]       ch_idle
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [LEVEL_BITS-1:0] LMAX   = '1;
  localparam logic [CH_BITS:0]      CH_LIM = (CH_BITS+1)'(CH_NUM);

  state_e                  state_q [CH_NUM];
  logic [COUNTER_BITS-1:0] cnt_q   [CH_NUM];
  logic [LEVEL_BITS-1:0]   lvl_q   [CH_NUM];
  logic [CH_NUM-1:0]       pend_on_q, pend_rel_q, pend_off_q, ch_idle_q;

  logic                    svc_vld, hit_svc;
  logic [CH_BITS-1:0]      svc_idx;
  state_e                  cur_state, state_d;
  logic [COUNTER_BITS-1:0] cur_cnt, cnt_d;
  logic [LEVEL_BITS-1:0]   cur_lvl, lvl_d, lvl_up, lvl_dn, lvl_on, slt;
  logic [7:0]              rate;
  logic [COUNTER_BITS:0]   sum;
  logic                    step, ev_on, ev_rel, ev_off, is_ads;

  assign svc_vld   = {1'b0, active} < CH_LIM;
  assign svc_idx   = svc_vld ? active : '0;
  assign cur_state = state_q[svc_idx];
  assign cur_cnt   = cnt_q[svc_idx];
  assign cur_lvl   = lvl_q[svc_idx];

  // Latched events for this channel plus any event aimed at it this very cycle
  assign hit_svc = svc_vld && (key_ch == active);
  assign ev_off  = pend_off_q[svc_idx] | (key_off     & hit_svc);
  assign ev_on   = pend_on_q[svc_idx]  | (key_on      & hit_svc);
  assign ev_rel  = pend_rel_q[svc_idx] | (key_release & hit_svc);

  assign is_ads = (cur_state == S_ATTACK) || (cur_state == S_DECAY) || (cur_state == S_SUSTAIN);
  assign slt    = {reg_sl, 1'b0};

  always_comb begin
    rate = 8'd0;
    case (cur_state)
      S_ATTACK:  rate = reg_ar;
      S_DECAY:   rate = reg_dr;
      S_SUSTAIN: rate = reg_sr;
      S_RELEASE: rate = reg_rr;
      default:   rate = 8'd0;
    endcase
  end

  assign sum    = (COUNTER_BITS+1)'(cur_cnt) + (COUNTER_BITS+1)'(rate);
  assign step   = sum[COUNTER_BITS];
  assign lvl_up = (step && cur_lvl != LMAX) ? cur_lvl + LEVEL_BITS'(1) : cur_lvl;
  assign lvl_dn = (step && cur_lvl != '0)   ? cur_lvl - LEVEL_BITS'(1) : cur_lvl;

`ifdef WTS_ADSR_LEGATO_EN
  assign lvl_on = is_ads ? cur_lvl : '0;
`else
  assign lvl_on = '0;
`endif

  // Next state of the serviced channel
  always_comb begin
    state_d = cur_state;
    lvl_d   = cur_lvl;
    cnt_d   = cur_cnt;
    if (!adsr_en[svc_idx]) begin
      // Gate mode: no ramps; without an event the channel is frozen
      cnt_d = '0;
      if (ev_off) begin
        state_d = S_IDLE;    lvl_d = '0;
      end else if (ev_on) begin
        state_d = S_SUSTAIN; lvl_d = LMAX;
      end else if (ev_rel) begin
        state_d = S_IDLE;    lvl_d = '0;
      end
    end else if (ev_off) begin
      state_d = S_IDLE;   lvl_d = '0;     cnt_d = '0;
    end else if (ev_on) begin
      state_d = S_ATTACK; lvl_d = lvl_on; cnt_d = '0;
    end else if (ev_rel && is_ads) begin
      state_d = S_RELEASE; cnt_d = '0;
    end else begin
      case (cur_state)
        S_ATTACK: begin
          lvl_d = lvl_up;
          cnt_d = sum[COUNTER_BITS-1:0];
          if (lvl_up == LMAX) begin
            state_d = S_DECAY; cnt_d = '0;
          end
        end
        S_DECAY: begin
          lvl_d = lvl_dn;
          cnt_d = sum[COUNTER_BITS-1:0];
          if ((lvl_dn <= slt) || (slt >= LMAX)) begin
            state_d = S_SUSTAIN; cnt_d = '0;
          end
        end
        S_SUSTAIN: begin
          lvl_d = lvl_dn;
          cnt_d = sum[COUNTER_BITS-1:0];
        end
        S_RELEASE: begin
          lvl_d = lvl_dn;
          cnt_d = sum[COUNTER_BITS-1:0];
          if (lvl_dn == '0) begin
            state_d = S_IDLE; cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int n = 0; n < CH_NUM; n++) begin
        state_q[n] <= S_IDLE;
        cnt_q[n]   <= '0;
        lvl_q[n]   <= '0;
      end
      pend_on_q  <= '0;
      pend_rel_q <= '0;
      pend_off_q <= '0;
      ch_idle_q  <= '1;
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        if (svc_vld && (active == CH_BITS'(n))) begin
          state_q[n]    <= state_d;
          cnt_q[n]      <= cnt_d;
          lvl_q[n]      <= lvl_d;
          pend_on_q[n]  <= 1'b0;
          pend_rel_q[n] <= 1'b0;
          pend_off_q[n] <= 1'b0;
          ch_idle_q[n]  <= (state_d == S_IDLE);
        end else begin
          pend_on_q[n]  <= pend_on_q[n]  | (key_on      && (key_ch == CH_BITS'(n)));
          pend_rel_q[n] <= pend_rel_q[n] | (key_release && (key_ch == CH_BITS'(n)));
          pend_off_q[n] <= pend_off_q[n] | (key_off     && (key_ch == CH_BITS'(n)));
          ch_idle_q[n]  <= (state_q[n] == S_IDLE);
        end
      end
    end
  end

  always_comb begin
    envelope = svc_vld ? cur_lvl : '0;
    ch_idle  = ch_idle_q;
  end

endmodule
